nx_fifo_prefetch: RTL and testbench
===================================

Name: nx_fifo_prefetch

Overview:
- Read-side consumer of the nx_fifo_ctrl pointer controller.
- Watches the controller's empty flag and issues ren pops; the FIFO RAM is addressed by the controller's rptr.
- Captures RAM read data, which has fixed 1-cycle latency, into a small prefetch buffer.
- Presents the words to the downstream stage on a valid/ready interface at full throughput, with no combinational ready-to-ren path.

Parameters:
- WIDTH, 32, data word width.
- PF_DEPTH, 3, prefetch buffer entries. Minimum 3; elaboration error if smaller.
- CNT_W, 2, width of pf_used. Must satisfy 2^CNT_W > PF_DEPTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- clear  in  1  flush request; same signal that drives the controller's clear.
- fifo_empty  in  1  controller empty flag.
- fifo_ren  out  1  pop request to controller; RAM read enable at the controller's rptr.
- mem_rdata  in  WIDTH  RAM read data, valid the cycle after fifo_ren.
- mem_rpar  in  1  odd parity of mem_rdata, same timing as mem_rdata.
- out_valid  out  1  downstream data valid.
- out_ready  in  1  downstream accept.
- out_data  out  WIDTH  head-of-buffer word.
- pf_used  out  CNT_W  words held in the buffer (excludes in-flight read).
- parity_err  out  1  sticky parity error.

Behaviour:
- Reset:
  - Synchronous, active-low: sampled on the clk rising edge only.
  - out_valid=0, fifo_ren=0, pf_used=0, parity_err=0, out_data=0, inflight=0, state=EMPTY.
- Occupancy:
  - occ = pf_used + inflight, where inflight is a 1-bit register equal to the previous cycle's fifo_ren.
- Issue rule:
  - fifo_ren = !fifo_empty && !clear && state!=FLUSH && occ < PF_DEPTH.
  - fifo_ren is a function of registered state, clear and fifo_empty only; out_ready never reaches it.
- Capture:
  - When inflight=1 and the read is not discarded, mem_rdata is written at the buffer tail on that edge.
- Pop:
  - A transfer occurs when out_valid && out_ready; the head is removed on that edge.
  - Simultaneous capture and pop: pf_used is unchanged, data order is preserved.
- Output:
  - out_valid = (pf_used != 0). out_data is the head entry, stable while out_valid && !out_ready.
- Latency: fifo_empty falling to out_valid rising is 2 cycles (ren in cycle N, capture at end of N+1, valid in N+2).
- Throughput: steady state with out_ready=1 is one word per cycle; occ reaches 2 < 3.
- FSM, from nx_fifo_prefetch_pkg:
  - EMPTY: pf_used=0 and inflight=0. Any ren → ACTIVE.
  - ACTIVE: data held or in flight. Pop that leaves pf_used=0 with no inflight and no new ren → EMPTY.
  - FLUSH: entered from any state when clear=1.
    - Buffer is emptied at that edge (pf_used=0, out_valid=0 next cycle).
    - If inflight=1, the returning word is discarded at the next edge.
    - fifo_ren is held 0 while in FLUSH.
    - Exits to EMPTY one cycle after clear deasserts.
    - clear held multiple cycles keeps the FSM in FLUSH.
- Boundaries:
  - fifo_empty is never violated: no ren while fifo_empty=1, so the controller's underflow must never assert.
  - Buffer full (pf_used=PF_DEPTH) with out_ready=0: no ren; out_data is held.
  - Buffer pointers wrap modulo PF_DEPTH. pf_used never exceeds PF_DEPTH; an assertion flags the violation.
  - clear and pop in the same cycle: clear wins; the popped word is considered transferred downstream.

Optional Feature:
- Macro: NX_FIFO_PREFETCH_PARITY_EN.
- When defined:
  - mem_rpar is stored with each entry.
  - At transfer, parity is recomputed over out_data; an odd-parity mismatch sets parity_err, which stays set until rst_n=0.
  - Data still passes through unchanged.
- When undefined:
  - mem_rpar is ignored and no parity storage is built.
  - parity_err is tied 0.
  - Ports stay identical in both builds.

Decomposition:
- Package nx_fifo_prefetch_pkg holds:
  - state enum {EMPTY, ACTIVE, FLUSH};
  - constant PF_DEPTH_MIN=3;
  - constant RAM_RD_LAT=1.
- One sub-module, nx_fifo_prefetch_buf:
  - PF_DEPTH-entry circular register buffer with push/pop/flush, head/tail pointers and count.
  - Width WIDTH, or WIDTH+1 with parity enabled.
- Issue logic and FSM stay in the top.

Test Plan:
- Cold start: fifo_empty drops at cycle 10 with words 0xA0..0xA4, out_ready=1 → ren at 10-14; out_valid from 12; out_data 0xA0..0xA4 on cycles 12-16; no gaps.
- Backpressure: out_ready=0 with 5 words available → exactly 3 rens, pf_used=3, ren stays 0. Raise out_ready → order 0xA0.. preserved, ren resumes after the first pop.
- Empty boundary: 1 word in the FIFO → single ren, fifo_empty=1 afterwards, zero further rens; controller underflow stays 0 throughout.
- Clear mid-stream: clear for 1 cycle while pf_used=2 and inflight=1 → out_valid=0 next cycle, returning word dropped, FSM passes through FLUSH to EMPTY, pf_used=0.
- Reset mid-operation: rst_n=0 for 1 cycle with pf_used=3 → all outputs at reset values after that edge; no ren issued during reset.
- Parity (macro on): word 0x1 driven with mem_rpar=1 → parity_err=1 at transfer, stays set until reset. Macro off → parity_err=0.

Source files
------------

// File: rtl/nx_fifo_prefetch_pkg.sv
// Shared state encoding and constants for the nx_fifo_prefetch read-side stage.
package nx_fifo_prefetch_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } pf_state_e;

  localparam int PF_DEPTH_MIN = 3;
  localparam int RAM_RD_LAT   = 1;

endpackage

// File: rtl/nx_fifo_prefetch_buf.sv
// Circular register buffer holding prefetched FIFO words; head is always
// presented on o_rdata, flush empties it in one edge.
module nx_fifo_prefetch_buf #(
  parameter int DW    = 32,
  parameter int DEPTH = 3,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [DW-1:0]    i_wdata,
  output logic [DW-1:0]    o_rdata,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_wdata;
        r_tail        <= ptr_inc(r_tail);
      end
      if (i_pop) r_head <= ptr_inc(r_head);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_head];
  assign o_count = r_count;

endmodule

// File: rtl/nx_fifo_prefetch.sv
// Read-side prefetch for the nx_fifo_ctrl pointer controller: pops RAM words
// ahead of demand and serves them on valid/ready. Optional per-word parity
// checking is built when NX_FIFO_PREFETCH_PARITY_EN is defined.
//
// state  | meaning
// EMPTY  | buffer empty, no read in flight
// ACTIVE | words held in the buffer and/or a read in flight
// FLUSH  | clear seen; buffer emptied, pops held off for one cycle
module nx_fifo_prefetch #(
  parameter int WIDTH    = 32,
  parameter int PF_DEPTH = 3,
  parameter int CNT_W    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             fifo_empty,
  output logic             fifo_ren,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_rpar,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] pf_used,
  output logic             parity_err
);

  import nx_fifo_prefetch_pkg::*;

  if (PF_DEPTH < PF_DEPTH_MIN) begin : g_bad_depth
    $error("nx_fifo_prefetch: PF_DEPTH must be at least %0d", PF_DEPTH_MIN);
  end
  if ((1 << CNT_W) <= PF_DEPTH) begin : g_bad_cnt_w
    $error("nx_fifo_prefetch: CNT_W too narrow for PF_DEPTH");
  end

`ifdef NX_FIFO_PREFETCH_PARITY_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif

  pf_state_e        r_state;
  pf_state_e        w_state_nxt;
  logic             r_inflight;
  logic [CNT_W:0]   w_occ;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_push;
  logic             w_xfer;
  logic             w_pop;
  logic [EW-1:0]    w_wdata;
  logic [EW-1:0]    w_rdata;

  // Issue depends only on registered state, clear and fifo_empty so that
  // out_ready never has a combinational path into the controller.
  assign w_occ    = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
  assign fifo_ren = rst_n && !fifo_empty && !clear && (r_state != FLUSH) &&
                    (w_occ < (CNT_W + 1)'(PF_DEPTH));

  assign w_push    = r_inflight && !clear && (r_state != FLUSH);
  assign out_valid = (w_count != '0);
  assign w_xfer    = out_valid && out_ready;
  assign w_pop     = w_xfer && !clear;
  assign w_count_nxt = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

  assign out_data = w_rdata[WIDTH-1:0];
  assign pf_used  = w_count;

  nx_fifo_prefetch_buf #(
    .DW    (EW),
    .DEPTH (PF_DEPTH),
    .CNT_W (CNT_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (clear),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= fifo_ren;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = FLUSH;
    end else begin
      case (r_state)
        EMPTY:   if (fifo_ren) w_state_nxt = ACTIVE;
        ACTIVE:  if ((w_count_nxt == '0) && !fifo_ren) w_state_nxt = EMPTY;
        FLUSH:   w_state_nxt = EMPTY;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

`ifdef NX_FIFO_PREFETCH_PARITY_EN
  logic r_parity_err;

  assign w_wdata = {mem_rpar, mem_rdata};

  // Checked on every transfer, including one that coincides with clear.
  always_ff @(posedge clk) begin
    if (!rst_n)                   r_parity_err <= 1'b0;
    else if (w_xfer && !(^w_rdata)) r_parity_err <= 1'b1;
  end

  assign parity_err = r_parity_err;
`else
  logic w_unused_par;

  assign w_unused_par = mem_rpar;
  assign w_wdata      = mem_rdata;
  assign parity_err   = 1'b0;
`endif

  a_pf_used_bound: assert property (@(posedge clk) disable iff (!rst_n)
    pf_used <= CNT_W'(PF_DEPTH));

endmodule

// File: tb/tb_nx_fifo_prefetch.sv
// Self-checking bench for nx_fifo_prefetch: emulates the FIFO controller and
// RAM, and predicts outputs from an in-order word list plus occupancy rules.
module tb_nx_fifo_prefetch;

  localparam int WIDTH    = 32;
  localparam int PF_DEPTH = 3;
  localparam int CNT_W    = 2;
`ifdef NX_FIFO_PREFETCH_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic             fifo_empty;
  logic             fifo_ren;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_rpar;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] pf_used;
  logic             parity_err;

  int total = 0;
  int bad   = 0;

  logic [WIDTH:0] q_fifo[$];
  logic [WIDTH:0] q_exp[$];
  logic [WIDTH:0] rd_word;
  bit             rd_pend;
  bit             clear_prev;
  bit             perr_exp;
  bit             underflow_seen;

  bit               s_ren;
  bit               s_val;
  bit               s_perr;
  logic [WIDTH-1:0] s_data;
  logic [CNT_W-1:0] s_pf;

  always #5 clk = ~clk;

  nx_fifo_prefetch #(
    .WIDTH    (WIDTH),
    .PF_DEPTH (PF_DEPTH),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .fifo_empty (fifo_empty),
    .fifo_ren   (fifo_ren),
    .mem_rdata  (mem_rdata),
    .mem_rpar   (mem_rpar),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .pf_used    (pf_used),
    .parity_err (parity_err)
  );

  function automatic logic [WIDTH:0] mk_word(input logic [WIDTH-1:0] d, input bit bad_par);
    return {(~(^d)) ^ bad_par, d};
  endfunction

  // One clock: drive inputs at negedge, check against the model, then advance it.
  task automatic step(input bit rdy, input bit clr, input bit rst);
    int             exp_pf;
    bit             exp_ren;
    bit             xfer;
    logic [WIDTH:0] w;
    @(negedge clk);
    rst_n      = !rst;
    out_ready  = rdy;
    clear      = clr;
    fifo_empty = (q_fifo.size() == 0);
    if (rd_pend) begin
      mem_rdata = rd_word[WIDTH-1:0];
      mem_rpar  = rd_word[WIDTH];
    end else begin
      mem_rdata = $urandom;
      mem_rpar  = 1'($urandom_range(0, 1));
    end
    #1;
    exp_pf  = q_exp.size() - (rd_pend ? 1 : 0);
    exp_ren = !rst && !fifo_empty && !clr && !clear_prev && (q_exp.size() < PF_DEPTH);
    s_ren  = fifo_ren;
    s_val  = out_valid;
    s_data = out_data;
    s_pf   = pf_used;
    s_perr = parity_err;
    total++;
    if (fifo_ren !== exp_ren) begin
      bad++;
      $display("FAIL ren t=%0t: got %b want %b", $time, fifo_ren, exp_ren);
    end
    total++;
    if (pf_used !== CNT_W'(exp_pf)) begin
      bad++;
      $display("FAIL pf_used t=%0t: got %0d want %0d", $time, pf_used, exp_pf);
    end
    total++;
    if (out_valid !== (exp_pf != 0)) begin
      bad++;
      $display("FAIL out_valid t=%0t: got %b want %b", $time, out_valid, exp_pf != 0);
    end
    if (exp_pf != 0) begin
      total++;
      if (out_data !== q_exp[0][WIDTH-1:0]) begin
        bad++;
        $display("FAIL out_data t=%0t: got %h want %h", $time, out_data, q_exp[0][WIDTH-1:0]);
      end
    end
    total++;
    if (parity_err !== perr_exp) begin
      bad++;
      $display("FAIL parity_err t=%0t: got %b want %b", $time, parity_err, perr_exp);
    end
    if (fifo_ren === 1'b1 && fifo_empty) underflow_seen = 1'b1;
    xfer = (out_valid === 1'b1) && rdy;
    @(posedge clk);
    if (rst) begin
      q_exp.delete();
      rd_pend    = 1'b0;
      clear_prev = 1'b0;
      perr_exp   = 1'b0;
    end else begin
      if (xfer && exp_pf != 0) begin
        w = q_exp.pop_front();
        if (PAR_EN && !(^w)) perr_exp = 1'b1;
      end
      if (clr) q_exp.delete();
      rd_pend = 1'b0;
      if (s_ren && q_fifo.size() != 0) begin
        w       = q_fifo.pop_front();
        rd_word = w;
        rd_pend = 1'b1;
        q_exp.push_back(w);
      end
      clear_prev = clr;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q_fifo.size() != 0 || q_exp.size() != 0) && n < 50) begin
      step(1'b1, 1'b0, 1'b0);
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL drain: got %0d cycles want < 50", n);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; clear = 1'b0; out_ready = 1'b1; fifo_empty = 1'b0;
    #1;
    total++;
    if (fifo_ren !== 1'b0) begin bad++; $display("FAIL rst_ren: got %b want 0", fifo_ren); end
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    total++;
    if (pf_used !== '0) begin bad++; $display("FAIL rst_pf: got %0d want 0", pf_used); end
    total++;
    if (out_data !== '0) begin bad++; $display("FAIL rst_data: got %h want 0", out_data); end
    total++;
    if (parity_err !== 1'b0) begin bad++; $display("FAIL rst_perr: got %b want 0", parity_err); end
    fifo_empty = 1'b1;
  endtask

  task automatic test_cold_start();
    int first_ren = -1;
    int first_val = -1;
    int last_val  = -1;
    int n_ren = 0;
    int n_val = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10)
        for (int k = 0; k < 5; k++) q_fifo.push_back(mk_word(32'(32'hA0 + k), 1'b0));
      step(1'b1, 1'b0, 1'b0);
      if (s_ren) begin n_ren++; if (first_ren < 0) first_ren = i; end
      if (s_val) begin n_val++; if (first_val < 0) first_val = i; last_val = i; end
    end
    total++;
    if (first_ren != 10) begin bad++; $display("FAIL cold_first_ren: got %0d want 10", first_ren); end
    total++;
    if (n_ren != 5) begin bad++; $display("FAIL cold_n_ren: got %0d want 5", n_ren); end
    total++;
    if (first_val != 12) begin bad++; $display("FAIL cold_first_val: got %0d want 12", first_val); end
    total++;
    if (n_val != 5 || last_val != 16) begin
      bad++;
      $display("FAIL cold_gapless: got n=%0d last=%0d want n=5 last=16", n_val, last_val);
    end
  endtask

  task automatic test_backpressure();
    int n_ren = 0;
    int first_ren = -1;
    for (int k = 0; k < 5; k++) q_fifo.push_back(mk_word(32'(32'hB0 + k), 1'b0));
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (s_ren) n_ren++;
    end
    total++;
    if (n_ren != 3) begin bad++; $display("FAIL bp_n_ren: got %0d want 3", n_ren); end
    total++;
    if (s_pf != CNT_W'(3) || s_ren) begin
      bad++;
      $display("FAIL bp_full: got pf=%0d ren=%b want pf=3 ren=0", s_pf, s_ren);
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (s_ren && first_ren < 0) first_ren = i;
    end
    total++;
    if (first_ren != 1) begin bad++; $display("FAIL bp_resume: got %0d want 1", first_ren); end
    drain();
  endtask

  task automatic test_empty_boundary();
    int n_ren = 0;
    int n_val = 0;
    q_fifo.push_back(mk_word(32'hC5, 1'b0));
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (s_ren) n_ren++;
      if (s_val) n_val++;
    end
    total++;
    if (n_ren != 1) begin bad++; $display("FAIL eb_n_ren: got %0d want 1", n_ren); end
    total++;
    if (n_val != 1) begin bad++; $display("FAIL eb_n_val: got %0d want 1", n_val); end
  endtask

  task automatic test_clear();
    for (int k = 0; k < 5; k++) q_fifo.push_back(mk_word(32'(32'hD0 + k), 1'b0));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    total++;
    if (s_pf != CNT_W'(2)) begin bad++; $display("FAIL clr_pre_pf: got %0d want 2", s_pf); end
    step(1'b0, 1'b0, 1'b0);
    total++;
    if (s_val || s_ren || s_pf != '0) begin
      bad++;
      $display("FAIL clr_flush: got val=%b ren=%b pf=%0d want 0 0 0", s_val, s_ren, s_pf);
    end
    step(1'b0, 1'b0, 1'b0);
    total++;
    if (!s_ren) begin bad++; $display("FAIL clr_restart: got ren=%b want 1", s_ren); end
    drain();
  endtask

  task automatic test_parity();
    q_fifo.push_back(mk_word(32'h1, 1'b1));
    q_fifo.push_back(mk_word(32'h3C, 1'b0));
    drain();
    step(1'b0, 1'b0, 1'b0);
    total++;
    if (s_perr != PAR_EN) begin bad++; $display("FAIL par_set: got %b want %b", s_perr, PAR_EN); end
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    total++;
    if (s_perr != PAR_EN) begin bad++; $display("FAIL par_sticky: got %b want %b", s_perr, PAR_EN); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0 && q_fifo.size() < 16) begin
        for (int k = 0; k < int'($urandom_range(1, 4)); k++)
          q_fifo.push_back(mk_word($urandom, $urandom_range(0, 19) == 0));
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, 1'b0);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) q_fifo.push_back(mk_word(32'(32'hE0 + k), 1'b0));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    total++;
    if (s_pf != CNT_W'(3) || s_ren) begin
      bad++;
      $display("FAIL rm_during: got pf=%0d ren=%b want pf=3 ren=0", s_pf, s_ren);
    end
    step(1'b0, 1'b0, 1'b0);
    total++;
    if (s_val || s_pf != '0 || s_data != '0 || s_perr) begin
      bad++;
      $display("FAIL rm_after: got val=%b pf=%0d data=%h perr=%b want all 0",
               s_val, s_pf, s_data, s_perr);
    end
    total++;
    if (!s_ren) begin bad++; $display("FAIL rm_restart: got ren=%b want 1", s_ren); end
    drain();
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; out_ready = 1'b0; fifo_empty = 1'b1;
    mem_rdata = '0; mem_rpar = 1'b0;
    rd_word = '0; rd_pend = 1'b0; clear_prev = 1'b0; perr_exp = 1'b0; underflow_seen = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_cold_start();
    test_backpressure();
    test_empty_boundary();
    test_clear();
    test_parity();
    test_random();
    test_reset_mid();
    total++;
    if (underflow_seen) begin bad++; $display("FAIL underflow: got ren with fifo_empty=1 want none"); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
